// File: rtl/router_pkg.sv
// Shared router definitions: flit geometry, route direction codes and
// destination-field placement used by the input buffers and the switch.
package router_pkg;

    localparam int ValidBitPos    = 81;
    localparam int lg_numprocs    = 3;
    localparam int FlitWidth      = ValidBitPos + 1;
    localparam int FlitChildWidth = FlitWidth + lg_numprocs;
    localparam int ROUTE_LEN      = 3;

    localparam int COORD_W   = 3;
    localparam int DST_X_LSB = 0;
    localparam int DST_Y_LSB = COORD_W;
    localparam int DST_Z_LSB = 2 * COORD_W;

    typedef enum logic [ROUTE_LEN-1:0] {
        DIR_LOCAL = 3'd0,
        DIR_XPOS  = 3'd1,
        DIR_YPOS  = 3'd2,
        DIR_ZPOS  = 3'd3,
        DIR_XNEG  = 3'd4,
        DIR_YNEG  = 3'd5,
        DIR_ZNEG  = 3'd6
    } dir_e;

endpackage

// File: rtl/input_route_buffer_if.sv
// Link-side and switch-side signals of one router input lane.
interface input_route_buffer_if;
    import router_pkg::*;

    logic [FlitChildWidth-1:0] in;
    logic                      in_valid;
    logic                      in_avail;
    logic [FlitChildWidth-1:0] out;
    logic [ROUTE_LEN-1:0]      route_out;
    logic                      out_valid;
    logic                      out_ready;

    modport slave (
        input  in, in_valid, out_ready,
        output in_avail, out, route_out, out_valid
    );

    modport master (
        output in, in_valid, out_ready,
        input  in_avail, out, route_out, out_valid
    );

endinterface

// File: rtl/input_route_buffer_flit_fifo.sv
// Synchronous FIFO holding flit plus precomputed route; head is read
// straight from registered storage, so a write is visible a cycle later.
module flit_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_q, wr_d;
    logic [PW-1:0]    rd_q, rd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign rdata_o = mem_q[rd_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (do_push) wr_d = wr_q + 1'b1;
        if (do_pop)  rd_d = rd_q + 1'b1;
        unique case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
            if (do_push) mem_q[wr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/input_route_buffer.sv
// Router input lane: buffers flits and tags each with its dimension-order
// torus direction at enqueue time so the switch sees the route with the head.
module input_route_buffer
    import router_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int COORD_W = 3,
    parameter int DIM_X   = 8,
    parameter int DIM_Y   = 8,
    parameter int DIM_Z   = 8,
    parameter int MY_X    = 0,
    parameter int MY_Y    = 0,
    parameter int MY_Z    = 0
) (
    input logic                 clk,
    input logic                 rst,
    input_route_buffer_if.slave bus
);

    localparam int DW = COORD_W + 1;
    localparam int EW = FlitChildWidth + ROUTE_LEN;
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [DW-1:0] HALF_X = DW'(DIM_X / 2);
    localparam logic [DW-1:0] HALF_Y = DW'(DIM_Y / 2);
    localparam logic [DW-1:0] HALF_Z = DW'(DIM_Z / 2);

    // Forward torus distance (dst - my) mod dim; operands are < dim.
    function automatic logic [DW-1:0] dist_f(
        logic [COORD_W-1:0] dst, int my, int dim
    );
        logic [DW:0] t;
        t = {2'b00, dst} + (DW+1)'(dim) - (DW+1)'(my);
        if (t >= (DW+1)'(dim)) t = t - (DW+1)'(dim);
        return t[DW-1:0];
    endfunction

    logic [DW-1:0]        dx, dy, dz;
    logic [ROUTE_LEN-1:0] route_d;
    logic [EW-1:0]        rdata_w;
    logic                 full_w, empty_w, push_w, pop_w;
    logic [CW-1:0]        count_w;

    assign dx = dist_f(bus.in[DST_X_LSB +: COORD_W], MY_X, DIM_X);
    assign dy = dist_f(bus.in[DST_Y_LSB +: COORD_W], MY_Y, DIM_Y);
    assign dz = dist_f(bus.in[DST_Z_LSB +: COORD_W], MY_Z, DIM_Z);

    // Distance exactly half the ring resolves to the positive direction.
    always_comb begin
        route_d = DIR_LOCAL;
        if (dx != '0)      route_d = (dx > HALF_X) ? DIR_XNEG : DIR_XPOS;
        else if (dy != '0) route_d = (dy > HALF_Y) ? DIR_YNEG : DIR_YPOS;
        else if (dz != '0) route_d = (dz > HALF_Z) ? DIR_ZNEG : DIR_ZPOS;
    end

    assign push_w = bus.in_valid && !full_w && bus.in[ValidBitPos];
    assign pop_w  = !empty_w && bus.out_ready;

    flit_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_w),
        .wdata_i ({route_d, bus.in}),
        .pop_i   (pop_w),
        .rdata_o (rdata_w),
        .full_o  (full_w),
        .empty_o (empty_w),
        .count_o (count_w)
    );

    assign bus.in_avail  = !full_w;
    assign bus.out_valid = !empty_w;
    assign bus.out       = rdata_w[FlitChildWidth-1:0];
    assign bus.route_out = rdata_w[EW-1:FlitChildWidth];

    always_comb begin
        assert (count_w <= CW'(DEPTH));
    end

endmodule

// File: tb/tb_input_route_buffer.sv
// Scoreboard bench for input_route_buffer (MY=0,0,0, DIM=8, DEPTH=4).
module tb_input_route_buffer;
    import router_pkg::*;

    localparam int W = FlitChildWidth;

    typedef struct packed {
        logic [W-1:0] flit;
        logic [2:0]   route;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    input_route_buffer_if bus ();

    input_route_buffer #(
        .DEPTH(4), .COORD_W(3),
        .DIM_X(8), .DIM_Y(8), .DIM_Z(8),
        .MY_X(0), .MY_Y(0), .MY_Z(0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    exp_t       sb[$];
    int         n_chk = 0;
    int         n_err = 0;
    int         n_pop = 0;
    int         seq   = 0;
    logic [2:0] cur_route;

    task automatic chk(string tag, logic [127:0] got, logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] mroute(int x, int y, int z);
        int c[3];
        c[0] = x; c[1] = y; c[2] = z;
        for (int i = 0; i < 3; i++) begin
            int d;
            d = (c[i] + 8) % 8;
            if (d != 0) return (d <= 4) ? 3'(i + 1) : 3'(i + 4);
        end
        return 3'd0;
    endfunction

    // Pop check first: a flit can never leave in the cycle it is accepted.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL pop_unexpected got=%0h exp=none", bus.out);
                end else begin
                    e = sb.pop_front();
                    chk("out_flit", bus.out, e.flit);
                    chk("out_route", bus.route_out, e.route);
                    n_pop++;
                end
            end
            if (bus.in_valid && bus.in_avail && bus.in[ValidBitPos])
                sb.push_back('{flit: bus.in, route: cur_route});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(int x, int y, int z, logic [2:0] r, logic vb);
        logic [W-1:0] f;
        f = '0;
        f[2:0] = 3'(x);
        f[5:3] = 3'(y);
        f[8:6] = 3'(z);
        f[40 +: 16] = 16'(seq);
        f[W-1 -: 3] = 3'($urandom);
        f[ValidBitPos] = vb;
        seq++;
        bus.in = f;
        bus.in_valid = 1'b1;
        cur_route = r;
    endtask

    task automatic drive_rand();
        int x, y, z;
        x = $urandom_range(0, 7);
        y = $urandom_range(0, 7);
        z = $urandom_range(0, 7);
        drive(x, y, z, mroute(x, y, z), 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    int tx[7] = '{5, 4, 0, 0, 0, 0, 2};
    int ty[7] = '{0, 0, 2, 6, 0, 0, 7};
    int tz[7] = '{0, 0, 0, 0, 7, 0, 1};
    logic [2:0] tr[7] = '{3'd4, 3'd1, 3'd2, 3'd5, 3'd6, 3'd0, 3'd1};

    initial begin
        int p0;
        rst = 1'b1;
        bus.in = '0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        cur_route = '0;
        repeat (2) step();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_in_avail", bus.in_avail, 1);
        chk("rst_out", bus.out, 0);
        chk("rst_route", bus.route_out, 0);

        // single flit, one cycle latency
        step();
        drive(3, 0, 0, 3'd1, 1'b1);
        step();
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("t1_valid", bus.out_valid, 1);
        chk("t1_route", bus.route_out, 1);
        step();
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk("t1_empty", bus.out_valid, 0);

        // routing table
        step();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            drive(tx[i], ty[i], tz[i], tr[i], 1'b1);
            step();
        end
        bus.in_valid = 1'b0;
        repeat (3) step();
        @(negedge clk);
        chk("t2_drained", sb.size(), 0);
        chk("t2_empty", bus.out_valid, 0);

        // fill, refuse fifth, drain in order
        step();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_rand();
            step();
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("t3_full_avail", bus.in_avail, 0);
        chk("t3_full_valid", bus.out_valid, 1);
        step();
        drive_rand();
        step();
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("t3_still_full", bus.in_avail, 0);
        chk("t3_sb_size", sb.size(), 4);
        p0 = n_pop;
        step();
        bus.out_ready = 1'b1;
        repeat (4) step();
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk("t3_pops", n_pop - p0, 4);
        chk("t3_empty", bus.out_valid, 0);

        // full with simultaneous push and pop
        step();
        for (int i = 0; i < 4; i++) begin
            drive_rand();
            step();
        end
        drive_rand();
        bus.out_ready = 1'b1;
        step();
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk("t4_avail", bus.in_avail, 1);
        chk("t4_count", dut.count_w, 3);
        step();
        bus.out_ready = 1'b1;
        repeat (3) step();
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk("t4_empty", bus.out_valid, 0);
        chk("t4_sb", sb.size(), 0);

        // steady stream
        p0 = n_pop;
        step();
        drive_rand();
        step();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            drive_rand();
            @(negedge clk);
            chk("t5_valid", bus.out_valid, 1);
            chk("t5_count", dut.count_w, 1);
            step();
        end
        bus.in_valid = 1'b0;
        step();
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk("t5_pops", n_pop - p0, 21);
        chk("t5_empty", bus.out_valid, 0);

        // invalid flit discarded, reset flushes
        step();
        bus.out_ready = 1'b1;
        drive(1, 0, 0, 3'd1, 1'b0);
        step();
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("t6_novalid", bus.out_valid, 0);
        chk("t6_nocount", dut.count_w, 0);
        step();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_rand();
            step();
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("t6_three", dut.count_w, 3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("t6_rst_valid", bus.out_valid, 0);
        chk("t6_rst_avail", bus.in_avail, 1);
        chk("t6_rst_count", dut.count_w, 0);

        step();
        chk("final_sb", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
